mips_cpu_hilo_unit: RTL and testbench

Multi-cycle multiply/divide unit owning the architectural HI/LO registers, sequencing MULT, MULTU, DIV, DIVU, MTHI and MTLO issued by the control decoder. Sits beside the ALU in the CPU datapath. Raises a stall to the pipeline whenever a new HI/LO operation or an MFHI/MFLO read collides with an in-flight iterative operation.

---
 rtl/mips_cpu_hilo_unit.sv | 191 +++++++++++++++++++
 tb/tb_mips_cpu_hilo_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_hilo_unit.sv
// rtl/mips_cpu_hilo_unit.sv - iterative multiply/divide unit owning the HI/LO registers
// Optional feature macro: MIPS_CPU_HILO_EARLY_EXIT_EN (multiply leaves CALC once the
// remaining multiplier magnitude is zero).
module mips_cpu_hilo_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_read,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  state_t      state;
  state_t      state_nxt;

  // Multiply: acc is the partial product, mcand the left-shifting multiplicand,
  // opb the right-shifting multiplier.
  // Divide: acc[63:32] is the partial remainder, acc[31:0] the quotient being
  // built, mcand[31:0] the dividend shifting out MSB first, opb the divisor.
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] opb;
  logic [31:0] a_raw;
  logic [5:0]  cnt;
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;
  logic        div_zero;

  logic        accept;
  logic        op_signed;
  logic        op_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        calc_last;

  logic [63:0] mult_acc_nxt;
  logic [32:0] div_shifted;
  logic        div_ok;
  logic [31:0] div_trial;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;

  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] hi_fix;
  logic [31:0] lo_fix;

  // Issue decode: only ops 0-3 start an iterative operation, and only from IDLE
  always_comb begin
    accept    = (state == IDLE) && start && (op[2] == 1'b0);
    op_signed = ~op[0];
    op_div    = op[1];
    a_mag     = (op_signed && a[31]) ? (32'd0 - a) : a;
    b_mag     = (op_signed && b[31]) ? (32'd0 - b) : b;
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mult_acc_nxt = opb[0] ? (acc + mcand) : acc;
    div_shifted  = {acc[63:32], mcand[31]};
    div_ok       = (div_shifted >= {1'b0, opb});
    div_trial    = div_shifted[31:0] - opb;
    rem_nxt      = div_ok ? div_trial : div_shifted[31:0];
    quo_nxt      = {acc[30:0], div_ok};
  end

  // Decide whether this CALC cycle is the last one
  always_comb begin
`ifdef MIPS_CPU_HILO_EARLY_EXIT_EN
    calc_last = (cnt == 6'd31) || (!is_div && (opb[31:1] == 31'd0));
`else
    calc_last = (cnt == 6'd31);
`endif
  end

  // Sign correction and divide-by-zero override applied in FIX
  always_comb begin
    prod_fix = neg_res ? (64'd0 - acc) : acc;
    quo_fix  = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
    rem_fix  = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
    if (!is_div) begin
      hi_fix = prod_fix[63:32];
      lo_fix = prod_fix[31:0];
    end else if (div_zero) begin
      hi_fix = a_raw;
      lo_fix = 32'hFFFF_FFFF;
    end else begin
      hi_fix = rem_fix;
      lo_fix = quo_fix;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (calc_last) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy covers CALC and FIX; stall is purely combinational
  always_comb begin
    busy  = (state != IDLE);
    stall = busy && (start || hilo_read);
  end

  // Datapath: operand latch, iteration, result write-back and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= 64'd0;
      mcand    <= 64'd0;
      opb      <= 32'd0;
      a_raw    <= 32'd0;
      cnt      <= 6'd0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            acc      <= 64'd0;
            mcand    <= {32'd0, a_mag};
            opb      <= b_mag;
            a_raw    <= a;
            cnt      <= 6'd0;
            is_div   <= op_div;
            neg_res  <= op_signed && (a[31] ^ b[31]);
            neg_rem  <= op_signed && op_div && a[31];
            div_zero <= op_div && (b == 32'd0);
          end else if (start && (op == OP_MTHI)) begin
            hi <= a;
          end else if (start && (op == OP_MTLO)) begin
            lo <= a;
          end
        end
        CALC: begin
          cnt   <= cnt + 6'd1;
          mcand <= {mcand[62:0], 1'b0};
          if (is_div) begin
            acc <= {rem_nxt, quo_nxt};
          end else begin
            acc <= mult_acc_nxt;
            opb <= {1'b0, opb[31:1]};
          end
        end
        FIX: begin
          hi   <= hi_fix;
          lo   <= lo_fix;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// tb/tb_mips_cpu_hilo_unit.sv - scoreboard bench for mips_cpu_hilo_unit
module tb_mips_cpu_hilo_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        hilo_read = 1'b0;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fails  = 0;

  logic [63:0] exp_q[$];
  int          lat_q[$];

  mips_cpu_hilo_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .hilo_read (hilo_read),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    logic [63:0] q;
    logic [63:0] m;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: model = sx * sy;
      3'd1: model = {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 32'd0) model = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          m = sx % sy;
          model = {m[31:0], q[31:0]};
        end
      end
      3'd3: model = (y == 32'd0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: model = 64'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] y);
    model_lat = 33;
`ifdef MIPS_CPU_HILO_EARLY_EXIT_EN
    if (o <= 3'd1) begin
      logic [31:0] mag;
      int k;
      mag = (o == 3'd0 && y[31]) ? (32'd0 - y) : y;
      k = 1;
      while (k < 32 && (mag >> k) != 32'd0) k++;
      model_lat = k + 1;
    end
`endif
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    exp_q.push_back(model(o, x, y));
    lat_q.push_back(model_lat(o, y));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      n = i;
      if (done) break;
    end
    check({tag, " latency"}, 64'(n), 64'(lat_q.pop_front()));
    check({tag, " busy at done"}, {63'd0, busy}, 64'd0);
    check({tag, " result"}, {hi, lo}, exp_q.pop_front());
  endtask

  task automatic move_to(input logic [2:0] o, input logic [31:0] x);
    start = 1'b1;
    op = o;
    a = x;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    logic [63:0] mres;
    int n;

    // Reset state and MTHI/MTLO
    #12;
    check("reset hi/lo", {hi, lo}, 64'd0);
    check("reset busy/done/stall", {61'd0, busy, done, stall}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    move_to(3'd4, 32'hDEAD_BEEF);
    check("mthi", {hi, lo}, {32'hDEAD_BEEF, 32'd0});
    move_to(3'd5, 32'hCAFE_F00D);
    check("mtlo", {hi, lo}, {32'hDEAD_BEEF, 32'hCAFE_F00D});
    check("mtlo busy/done", {62'd0, busy, done}, 64'd0);
    move_to(3'd6, 32'h1111_1111);
    check("op6 ignored", {hi, lo, 30'd0, busy, done}, {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'd0});

    // Asynchronous reset mid-cycle
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset hi/lo", {hi, lo}, 64'd0);
    check("async reset busy/done", {62'd0, busy, done}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed and random arithmetic
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult -3*7");
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu max");
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div -7/2");
    issue(3'd3, 32'd7, 32'd0);
    wait_done("divu by zero");
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div overflow");
    issue(3'd2, 32'd100, 32'hFFFF_FFF3);
    wait_done("div 100/-13");
    for (int t = 0; t < 6; t++) begin
      logic [2:0] ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (t == 2) ? 32'd0 : $urandom;
      issue(ro, ra, rb);
      wait_done("random op");
    end

    // Hazard: MFHI read and MTLO held while a multiply is in flight
    issue(3'd0, 32'd5, 32'hFFFF_FFF7);
    mres = exp_q[0];
    hilo_read = 1'b1;
    start = 1'b1;
    op = 3'd5;
    a = 32'h0000_1234;
    n = 0;
    check("stall first busy cycle", {63'd0, stall}, 64'd1);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      n = i;
      if (done) break;
      check("stall while busy", {63'd0, stall}, 64'd1);
    end
    check("hazard latency", 64'(n), 64'(lat_q.pop_front()));
    check("stall in done cycle", {63'd0, stall}, 64'd0);
    check("hazard mult result", {hi, lo}, exp_q.pop_front());
    @(posedge clk);
    #1;
    start = 1'b0;
    hilo_read = 1'b0;
    check("mtlo after done", {hi, lo}, {mres[63:32], 32'h0000_1234});
    check("mtlo stays idle", {63'd0, busy}, 64'd0);

    // Reset during DIVU iteration, then a clean MULTU
    issue(3'd3, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset mid-op hi/lo", {hi, lo}, 64'd0);
    check("reset mid-op busy/done/stall", {61'd0, busy, done, stall}, 64'd0);
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(3'd1, 32'd6, 32'd7);
    wait_done("multu 6*7 after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
